// File: rtl/adder_bist.sv
// Exhaustive BIST for a WIDTH-bit combinational adder. Every {c_in,a,b} vector is driven
// for one settling cycle, then compared; the mismatch count and first failing index are kept.

module adder_bist_cmp #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic [WIDTH-1:0] sum,
    input  logic             c_out,
    output logic             mismatch
);
    logic [WIDTH:0] expected;

    assign expected = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
    assign mismatch = (expected != {c_out, sum});
endmodule

module adder_bist #(
    parameter int WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   a,
    output logic [WIDTH-1:0]   b,
    output logic               c_in,
    input  logic [WIDTH-1:0]   sum,
    input  logic               c_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH+1:0] err_count,
    output logic [2*WIDTH:0]   first_fail
);
    localparam int VW = 2*WIDTH + 1;
    localparam int CW = 2*WIDTH + 2;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRIVE  = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    typedef struct packed {
        logic [CW-1:0] err_count;
        logic [VW-1:0] first_fail;
        logic          fail_seen;
    } result_t;

    logic [1:0]    state;
    logic [VW-1:0] vec;
    result_t       res;
    logic          mismatch;

    // Operands come straight from the vector register so the adder sees stable inputs.
    assign c_in = vec[VW-1];
    assign a    = vec[VW-2:WIDTH];
    assign b    = vec[WIDTH-1:0];

    adder_bist_cmp #(.WIDTH(WIDTH)) u_cmp (
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .sum      (sum),
        .c_out    (c_out),
        .mismatch (mismatch)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            vec   <= '0;
            res   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state <= S_DRIVE;
                        vec   <= '0;
                        res   <= '0;
                    end
                end
                S_DRIVE: state <= S_SAMPLE;
                S_SAMPLE: begin
                    if (mismatch) begin
                        // Saturate defensively; a full run cannot exceed 2^VW errors anyway.
                        if (res.err_count != '1)
                            res.err_count <= res.err_count + 1'b1;
                        if (!res.fail_seen) begin
                            res.first_fail <= vec;
                            res.fail_seen  <= 1'b1;
                        end
                    end
                    if (vec == '1) begin
                        state <= S_DONE;
                    end else begin
                        vec   <= vec + 1'b1;
                        state <= S_DRIVE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy       = (state == S_DRIVE) || (state == S_SAMPLE);
    assign done       = (state == S_DONE);
    assign pass       = done && (res.err_count == '0);
    assign err_count  = res.err_count;
    assign first_fail = res.first_fail;
endmodule

// File: tb/tb_adder_bist.sv
// Directed bench for adder_bist (WIDTH=3) with a behavioural adder that can carry
// a stuck-at fault on c_out or sum[0].

module tb_adder_bist;
    localparam int WIDTH = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [WIDTH-1:0]   a, b;
    logic               c_in;
    logic [WIDTH-1:0]   sum;
    logic               c_out;
    logic               busy, done, pass;
    logic [2*WIDTH+1:0] err_count;
    logic [2*WIDTH:0]   first_fail;

    int mode = 0;   // 0 good, 1 c_out stuck 0, 2 sum[0] stuck 0
    int checks = 0;
    int errors = 0;
    int cyc;

    always #5 clk = ~clk;

    always_comb begin
        {c_out, sum} = {1'b0, a} + {1'b0, b} + {3'b000, c_in};
        if (mode == 1) c_out = 1'b0;
        if (mode == 2) sum[0] = 1'b0;
    end

    adder_bist #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .c_in       (c_in),
        .sum        (sum),
        .c_out      (c_out),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .first_fail (first_fail)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Start a run; optionally re-pulse start or assert rst at a given cycle into the run.
    task automatic run(input int pulse_at, input int rst_at, output int n);
        @(negedge clk) start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 1);
        chk("err_cleared", {24'd0, err_count}, 0);
        chk("vec0", {29'd0, c_in, a, b}, 0);
        n = 0;
        while (!done && n < 400) begin
            @(posedge clk) #1;
            n++;
            if (n == 31) chk("vec_at_31", {25'd0, c_in, a, b}, 15);
            if (n == 60) chk("pass_low_busy", {31'd0, pass}, 0);
            if (n == pulse_at) start = 1'b1;
            if (n == pulse_at + 1) start = 1'b0;
            if (n == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_busy", {31'd0, busy}, 0);
                chk("rst_done", {31'd0, done}, 0);
                chk("rst_pass", {31'd0, pass}, 0);
                chk("rst_err", {24'd0, err_count}, 0);
                chk("rst_ff", {25'd0, first_fail}, 0);
                chk("rst_vec", {29'd0, c_in, a, b}, 0);
                return;
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_done", {31'd0, done}, 0);
        chk("reset_err", {24'd0, err_count}, 0);
        chk("reset_ab", {29'd0, c_in, a, b}, 0);
        @(negedge clk) rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_hold_busy", {31'd0, busy}, 0);
        chk("idle_hold_done", {31'd0, done}, 0);

        // Good adder, start re-pulsed mid-run must be ignored
        mode = 0;
        run(50, -1, cyc);
        chk("good_cycles", cyc, 256);
        chk("good_done", {31'd0, done}, 1);
        chk("good_pass", {31'd0, pass}, 1);
        chk("good_err", {24'd0, err_count}, 0);
        chk("good_ff", {25'd0, first_fail}, 0);
        chk("good_last_vec", {29'd0, c_in, a, b}, 127);
        repeat (5) @(posedge clk);
        #1;
        chk("done_hold", {31'd0, done}, 1);
        chk("done_hold_vec", {29'd0, c_in, a, b}, 127);

        // c_out stuck at 0, started from DONE
        mode = 1;
        run(-1, -1, cyc);
        chk("cout_cycles", cyc, 256);
        chk("cout_pass", {31'd0, pass}, 0);
        chk("cout_err", {24'd0, err_count}, 64);
        chk("cout_ff", {25'd0, first_fail}, 15);

        // sum[0] stuck at 0; previous 64 errors must not carry over
        mode = 2;
        run(-1, -1, cyc);
        chk("s0_cycles", cyc, 256);
        chk("s0_err", {24'd0, err_count}, 64);
        chk("s0_ff", {25'd0, first_fail}, 1);

        // Good adder rerun from DONE
        mode = 0;
        run(-1, -1, cyc);
        chk("rerun_cycles", cyc, 256);
        chk("rerun_err", {24'd0, err_count}, 0);
        chk("rerun_pass", {31'd0, pass}, 1);

        // Faulty adder aborted by async reset at cycle 100
        mode = 1;
        run(-1, 100, cyc);
        @(negedge clk) rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_idle", {30'd0, busy, done}, 0);
        run(-1, -1, cyc);
        chk("after_rst_cycles", cyc, 256);
        chk("after_rst_err", {24'd0, err_count}, 64);
        chk("after_rst_ff", {25'd0, first_fail}, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adder_bist.md
ADDER_BIST -- requirements
Module: adder_bist

Interface
REQ-001 Parameter: WIDTH, default 3, operand width of the adder under test.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request an exhaustive test run; sampled only in IDLE or DONE.
REQ-005 a  output  WIDTH  operand A driven to the adder under test.
REQ-006 b  output  WIDTH  operand B driven to the adder under test.
REQ-007 c_in  output  1  carry-in driven to the adder under test.
REQ-008 sum  input  WIDTH  sum returned by the adder under test.
REQ-009 c_out  input  1  carry-out returned by the adder under test.
REQ-010 busy  output  1  high while a run is in progress (DRIVE or SAMPLE).
REQ-011 done  output  1  high while in DONE; level, not pulse.
REQ-012 pass  output  1  valid when done=1; high iff err_count==0.
REQ-013 err_count  output  2*WIDTH+2  number of mismatching vectors in the last run.
REQ-014 first_fail  output  2*WIDTH+1  vector index of the first mismatch; 0 if none.

Function
REQ-015 Vector register vec (2*WIDTH+1 bits) SHALL drive c_in=vec[2W], a=vec[2W-1:W], b=vec[W-1:0] combinationally from the register; the adder is driven from registers only.
REQ-016 FSM states SHALL be IDLE, DRIVE, SAMPLE, DONE.
REQ-017 IDLE or DONE with start=1 at an edge -> DRIVE; vec<=0, err_count<=0, first_fail<=0, failure-seen flag<=0.
REQ-018 DRIVE -> SAMPLE unconditionally after one cycle (settling cycle for the combinational adder).
REQ-019 In SAMPLE, at the edge, expected = a+b+c_in computed at WIDTH+1 bits, compared against {c_out,sum}.
REQ-020 On mismatch: err_count increments by 1; if no prior failure this run, first_fail<=vec and failure-seen flag set.
REQ-021 SAMPLE with vec != all-ones -> vec<=vec+1, state DRIVE; SAMPLE with vec == all-ones -> DONE, vec held.
REQ-022 Run length: vector n compared at start-edge + 2n+2; DONE entered at start-edge + 2^(2W+2) edges (256 for WIDTH=3).
REQ-023 err_count SHALL never wrap: maximum 2^(2W+1) fits its width.
REQ-024 start while busy=1 SHALL be ignored; no restart, no counter change.
REQ-025 DONE SHALL hold err_count, first_fail, pass, and the last vector on a/b/c_in until start or rst.
REQ-026 pass SHALL be 0 whenever done=0.
REQ-027 sum/c_out values outside SAMPLE SHALL have no effect on any state.

Reset
REQ-028 rst=1 SHALL immediately, without a clock, force state IDLE, vec=0 (a=0, b=0, c_in=0), busy=0, done=0, pass=0, err_count=0, first_fail=0.
REQ-029 rst asserted mid-run SHALL abort the run; no partial results are retained.
REQ-030 After rst deasserts, the block SHALL remain in IDLE until start=1 is sampled.

Verification
REQ-031 WIDTH=3, correct ripple adder, start pulse -> busy for 256 cycles, then done=1, pass=1, err_count=0, first_fail=0.
REQ-032 WIDTH=3, c_out stuck at 0 -> done=1, pass=0, err_count=64, first_fail=15 (c_in=0, a=1, b=7).
REQ-033 WIDTH=3, sum[0] stuck at 0 -> err_count=64, first_fail=1 (a=0, b=1, c_in=0).
REQ-034 Correct adder; start re-pulsed at cycle 50 of a run -> ignored; done still at cycle 256; then start in DONE -> err_count cleared, full rerun of 256 cycles.
REQ-035 Faulty adder (c_out stuck 0); rst pulsed at cycle 100 of a run -> all outputs 0 asynchronously, state IDLE; next start -> err_count=64 with no carry-over.
